// File: rtl/trig_conditioner.sv
// Push-button / sensor input conditioner: 2-flop synchroniser, 4-state debounce FSM,
// single-cycle trigger on each accepted rising edge, and a saturating bounce counter.
module trig_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       glitch_clr,
    output logic       trig_out,
    output logic       level_out,
    output logic [3:0] glitch_cnt
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic             s1, s2;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             trig_q, trig_d;
    logic [3:0]       glitch_q, glitch_d;
    logic             abort;

    // Synchroniser stage: only s2 is ever seen by the FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Debounce FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            trig_q   <= 1'b0;
            glitch_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            trig_q   <= trig_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        trig_d  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE_LO: begin
                level_d = 1'b0;
                if (s2) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s2) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    trig_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                level_d = 1'b1;
                if (!s2) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                // Falling acceptance mirrors the rising one but never triggers
                if (s2) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // A clear in the same cycle as an abort wins
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr)
            glitch_d = 4'd0;
        else if (abort)
            glitch_d = sat_inc(glitch_q);
    end

    assign trig_out   = trig_q;
    assign level_out  = level_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_trig_conditioner.sv
// Scoreboard bench for trig_conditioner (DB_CYCLES=4) with a behavioural model of the
// downstream 3-high pulse generator driven from trig_out.
module tb_trig_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       glitch_clr;
    logic       trig_out;
    logic       level_out;
    logic [3:0] glitch_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tq[$];
    int zq[$];
    int zc     = 0;
    logic z, z_prev;
    int z_len  = 0;

    trig_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .glitch_clr (glitch_clr),
        .trig_out   (trig_out),
        .level_out  (level_out),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream generator model: high for 3 cycles starting the cycle after a trigger
    always @(posedge clk) begin
        if (trig_out)    zc <= 3;
        else if (zc > 0) zc <= zc - 1;
    end
    assign z = (zc > 0);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected trigger / downstream-pulse times whenever they appear
    initial z_prev = 1'b0;
    always @(negedge clk) begin
        if (trig_out === 1'b1) begin
            if (tq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL trig_unexpected actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                chk("trig_time", cyc, tq.pop_front());
                chk("level_at_trig", int'(level_out), 1);
                zq.push_back(cyc + 1);
            end
        end
        if (z && !z_prev) begin
            z_len = 1;
            if (zq.size() == 0) chk("z_unexpected", 1, 0);
            else                chk("z_start", cyc, zq.pop_front());
        end else if (z) begin
            z_len++;
        end else if (z_prev) begin
            chk("z_len", z_len, 3);
        end
        z_prev = z;
    end

    task automatic drive(input logic v, input int n);
        btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        rst        = 1'b0;
        btn_in     = 1'b0;
        glitch_clr = 1'b0;

        // 1: reset and clean press
        wait_n(2);
        chk("rst_level", int'(level_out), 0);
        chk("rst_trig", int'(trig_out), 0);
        chk("rst_glitch", int'(glitch_cnt), 0);
        rst = 1'b1;
        wait_n(1);
        c = cyc;
        tq.push_back(c + 6);
        drive(1'b1, 5);
        chk("t1_level_before", int'(level_out), 0);
        wait_n(1);
        chk("t1_level_after", int'(level_out), 1);
        wait_n(6);
        chk("t1_glitch", int'(glitch_cnt), 0);

        // 2: bounce rejection on the way up
        drive(1'b0, 10);
        chk("t2_level_low", int'(level_out), 0);
        drive(1'b1, 2);
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, 1);
        c = cyc;
        tq.push_back(c + 6);
        drive(1'b1, 5);
        chk("t2_level_before", int'(level_out), 0);
        wait_n(1);
        chk("t2_level_after", int'(level_out), 1);
        wait_n(6);
        chk("t2_glitch", int'(glitch_cnt), 2);

        // 3: release with bounce, no trigger on the way down
        drive(1'b0, 2);
        drive(1'b1, 1);
        c = cyc;
        drive(1'b0, 5);
        chk("t3_level_before", int'(level_out), 1);
        wait_n(1);
        chk("t3_level_after", int'(level_out), 0);
        chk("t3_glitch", int'(glitch_cnt), 3);
        wait_n(6);

        // 4: reset during the third high sample
        drive(1'b1, 4);
        rst = 1'b0;
        wait_n(1);
        chk("t4_level", int'(level_out), 0);
        chk("t4_trig", int'(trig_out), 0);
        chk("t4_glitch", int'(glitch_cnt), 0);
        chk("t4_state", int'(dut.state_q), 0);
        rst = 1'b1;
        c = cyc;
        tq.push_back(c + 6);
        wait_n(10);
        chk("t4_level_after", int'(level_out), 1);

        // 5: saturation at 15, then clear coincident with an abort
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1);
            drive(1'b1, 4);
            chk("t5_glitch_sat", int'(glitch_cnt), (i + 1 > 15) ? 15 : i + 1);
        end
        drive(1'b0, 1);
        drive(1'b1, 2);
        glitch_clr = 1'b1;
        wait_n(1);
        glitch_clr = 1'b0;
        chk("t5_clear_wins", int'(glitch_cnt), 0);
        wait_n(3);
        chk("t5_clear_hold", int'(glitch_cnt), 0);
        chk("t5_level", int'(level_out), 1);

        // 6: two presses 100 ns apart feeding the downstream generator
        drive(1'b0, 10);
        chk("t6_level_low", int'(level_out), 0);
        c = cyc;
        tq.push_back(c + 6);
        tq.push_back(c + 16);
        drive(1'b1, 5);
        drive(1'b0, 5);
        drive(1'b1, 15);
        chk("t6_level", int'(level_out), 1);
        chk("t6_glitch", int'(glitch_cnt), 0);

        chk("trig_pending", tq.size(), 0);
        chk("z_pending", zq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
